// File: rtl/round_key_gen_pkg.sv
// Shared types, constants and S-box helpers for the AES-128 round key generator.
// Holds the FSM encoding, round-code offset, Rcon/SubWord helpers and FIPS-197 test keys.
package round_key_gen_pkg;

  localparam int AES_NUM_ROUNDS = 10;
  localparam int ROUND_OFS      = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_EMIT   = 2'd2
  } state_e;

  localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  localparam logic [7:0] SBOX [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]],
            SBOX[w[15:8]],  SBOX[w[7:0]]};
  endfunction

  function automatic logic [7:0] rcon_of(input logic [3:0] n);
    logic [7:0] r;
    r = 8'h00;
    unique case (n)
      4'd0: r = 8'h01;
      4'd1: r = 8'h02;
      4'd2: r = 8'h04;
      4'd3: r = 8'h08;
      4'd4: r = 8'h10;
      4'd5: r = 8'h20;
      4'd6: r = 8'h40;
      4'd7: r = 8'h80;
      4'd8: r = 8'h1b;
      4'd9: r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/round_key_gen_key_exp.sv
// One AES-128 key-schedule step, forward (next round key) or inverse (previous).
// Ports: i_Key current key, i_Round round code, i_fDec direction, o_Key result.
module round_key_gen_key_exp
  import round_key_gen_pkg::*;
(
  input  logic [127:0] i_Key,
  input  logic [3:0]   i_Round,
  input  logic         i_fDec,
  output logic [127:0] o_Key
);

  localparam logic [3:0] OFS = 4'(ROUND_OFS);

  logic [3:0]  rc_sel;
  logic [7:0]  rcon;
  logic [31:0] w0, w1, w2, w3;
  logic [31:0] t, sw;
  logic [31:0] n0, n1, n2, n3;

  always_comb begin
    // Inverse codes are complemented so both directions share one Rcon table.
    rc_sel = i_fDec ? (i_Round ^ 4'hF) : i_Round;
    rcon   = rcon_of(rc_sel - OFS);
    {w0, w1, w2, w3} = i_Key;
    // Inverse: the previous w3 must be recovered first, it feeds SubWord.
    t  = i_fDec ? (w3 ^ w2) : w3;
    sw = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
    if (i_fDec) begin
      n0 = w0 ^ sw;
      n1 = w1 ^ w0;
      n2 = w2 ^ w1;
      n3 = t;
    end else begin
      n0 = w0 ^ sw;
      n1 = w1 ^ n0;
      n2 = w2 ^ n1;
      n3 = w3 ^ n2;
    end
    o_Key = {n0, n1, n2, n3};
  end

endmodule

// File: rtl/round_key_gen.sv
// Iterative AES-128 round key sequencer: emits keys 0..10 (enc) or 10..0 (dec).
// Ports: i_Start/i_Key/i_fDec start, i_Abort, i_Ready handshake; o_* key/idx/valid/last/busy.
module round_key_gen
  import round_key_gen_pkg::*;
#(
  parameter bit DEC_CACHE  = 1'b1,
  parameter int NUM_ROUNDS = AES_NUM_ROUNDS
) (
  input  logic         i_Clk,
  input  logic         i_Rst_n,
  input  logic         i_Start,
  input  logic [127:0] i_Key,
  input  logic         i_fDec,
  input  logic         i_Abort,
  input  logic         i_Ready,
  output logic [127:0] o_RoundKey,
  output logic [3:0]   o_RoundIdx,
  output logic         o_Valid,
  output logic         o_Last,
  output logic         o_Busy
);

  localparam logic [3:0] LAST = 4'(NUM_ROUNDS);
  localparam logic [3:0] OFS  = 4'(ROUND_OFS);

  state_e       state_q;
  logic [127:0] key_q;
  logic [127:0] org_q;
  logic [127:0] c_key_q;
  logic [127:0] c_rk_q;
  logic         c_vld_q;
  logic         dec_q;
  logic [3:0]   idx_q;
  logic [3:0]   cnt_q;

  logic [127:0] exp_key;
  logic [3:0]   exp_round;
  logic         exp_dec;
  logic         hit;

  round_key_gen_key_exp u_key_exp (
    .i_Key   (key_q),
    .i_Round (exp_round),
    .i_fDec  (exp_dec),
    .o_Key   (exp_key)
  );

  always_comb begin
    exp_dec = (state_q == ST_EMIT) && dec_q;
    if (state_q == ST_EXPAND)
      exp_round = cnt_q + OFS;
    else if (dec_q)
      exp_round = LAST + OFS - idx_q;
    else
      exp_round = idx_q + OFS;
    hit = DEC_CACHE && c_vld_q && (c_key_q == i_Key);
  end

  assign o_Valid    = (state_q == ST_EMIT);
  assign o_Busy     = (state_q != ST_IDLE);
  assign o_RoundKey = key_q;
  assign o_RoundIdx = idx_q;
  assign o_Last     = o_Valid &&
                      (dec_q ? (idx_q == 4'd0) : (idx_q == LAST));

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      state_q <= ST_IDLE;
      key_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      dec_q   <= 1'b0;
      c_vld_q <= 1'b0;
    end else if (i_Abort) begin
      state_q <= ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: if (i_Start) begin
          dec_q <= i_fDec;
          org_q <= i_Key;
          if (!i_fDec) begin
            key_q   <= i_Key;
            idx_q   <= '0;
            state_q <= ST_EMIT;
          end else if (hit) begin
            key_q   <= c_rk_q;
            idx_q   <= LAST;
            state_q <= ST_EMIT;
          end else begin
            key_q   <= i_Key;
            cnt_q   <= '0;
            state_q <= ST_EXPAND;
          end
        end
        ST_EXPAND: begin
          key_q <= exp_key;
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == LAST - 4'd1) begin
            idx_q   <= LAST;
            state_q <= ST_EMIT;
            // Only a completed expansion may populate the cache.
            if (DEC_CACHE) begin
              c_vld_q <= 1'b1;
              c_key_q <= org_q;
              c_rk_q  <= exp_key;
            end
          end
        end
        ST_EMIT: if (i_Ready) begin
          if (o_Last) begin
            state_q <= ST_IDLE;
          end else begin
            key_q <= exp_key;
            idx_q <= dec_q ? idx_q - 4'd1 : idx_q + 4'd1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/round_key_gen.md
Name: round_key_gen

Overview:
- Sequential AES-128 key-schedule controller that sits directly upstream of the round datapath.
- Drives one KeyExpansion instance iteratively and emits the 11 round keys one per handshake.
- Encryption order is 0..10. Decryption order is 10..0.
- For decryption, a 10-cycle forward pre-expansion first reaches round key 10. An optional cache skips this when the same cipher key is restarted in decrypt mode.

Parameters:
- DEC_CACHE, 1: 1 = retain cipher key and round-10 key after a pre-expansion, so a decrypt restart with an identical key skips EXPAND. 0 = always expand.
- NUM_ROUNDS, 10: fixed for AES-128. Any other value is unsupported.

Ports:
- i_Clk  in  1  single clock, rising edge
- i_Rst_n  in  1  synchronous active-low reset
- i_Start  in  1  start pulse; sampled only in IDLE
- i_Key  in  128  cipher key, captured on accepted i_Start
- i_fDec  in  1  mode, captured on accepted i_Start; 1 = decrypt order
- i_Abort  in  1  return to IDLE next cycle from any state
- i_Ready  in  1  consumer accepts o_RoundKey when o_Valid & i_Ready
- o_RoundKey  out  128  current round key
- o_RoundIdx  out  4  AES round index of o_RoundKey (0..10)
- o_Valid  out  1  o_RoundKey/o_RoundIdx valid
- o_Last  out  1  asserted with the final key (idx 10 enc, idx 0 dec)
- o_Busy  out  1  high in any state except IDLE

Behaviour:
- Reset (i_Rst_n=0 at an edge): state IDLE. o_RoundKey=0, o_RoundIdx=0, o_Valid=0, o_Last=0, o_Busy=0. Cache valid flag cleared. Reset mid-sequence discards all progress.
- States: IDLE, EXPAND, EMIT.
- IDLE, i_Start=1:
  - Latch key into key register and latch mode.
  - Enc: key reg = i_Key, idx=0 -> EMIT. o_Valid=1 on the next cycle (latency 1).
  - Dec with cache hit (DEC_CACHE=1, cache valid, stored key == i_Key): key reg = cached round-10 key, idx=10 -> EMIT (latency 1).
  - Dec otherwise: key reg = i_Key, cnt=0 -> EXPAND.
- EXPAND:
  - Each cycle, key reg <= KeyExpansion(key reg, i_Round=cnt+3, i_fDec=0) and cnt++.
  - After 10 updates (cnt==9 step): idx=10 -> EMIT; cache stores i_Key and round-10 key, cache valid=1.
  - First o_Valid comes 11 cycles after i_Start.
  - o_Valid=0 throughout EXPAND.
- EMIT:
  - o_Valid=1, o_RoundKey=key reg, o_RoundIdx=idx.
  - o_Valid & !i_Ready: hold all outputs stable (no change while stalled).
  - Accept, enc: key reg <= KeyExpansion(key reg, i_Round=idx+3, i_fDec=0), idx++.
  - Accept, dec: key reg <= KeyExpansion(key reg, i_Round=13-idx, i_fDec=1), idx--. The expander maps i_Round^4'hF to the correct Rcon; idx 10 uses i_Round 3 (Rcon 36) and idx 1 uses i_Round 12 (Rcon 01).
  - Accept with o_Last: -> IDLE, o_Valid=0 next cycle. Back-to-back i_Start is accepted only from IDLE, so there is a minimum of one idle cycle between sequences.
- o_Last = o_Valid & (enc ? idx==10 : idx==0).
- i_Start while not IDLE: ignored; has no effect on the latched key or mode.
- i_Abort (priority below reset, above all else): -> IDLE, o_Valid=0, o_Busy=0.
  - Abort during EXPAND leaves cache valid unchanged; a partial expansion never writes the cache.
  - i_Start in the same cycle as i_Abort in IDLE: abort wins, start ignored.
- Enc-mode starts never modify the cache.
- The KeyExpansion mode pin is 0 in EXPAND and equals the latched mode in EMIT.

Decomposition:
- Shared package:
  - AES_NUM_ROUNDS = 10
  - ROUND_OFS = 3 (expander round-code offset)
  - state encoding IDLE/EXPAND/EMIT, 2 bits
  - FIPS-197 test key constants for benches
- Sub-module: exactly one instance of the existing KeyExpansion; this block adds only registers, the counter, the FSM and the cache.

Test Plan:
- Enc, key 2b7e151628aed2a6abf7158809cf4f3c, i_Ready=1:
  - 11 consecutive valid cycles starting 1 cycle after start.
  - idx 0 = the key itself.
  - idx 1 = a0fafe1788542cb123a339392a6c7605.
  - idx 10 = d014f9a8c9ee2589e13f0cc8b6630ca6 with o_Last=1.
- Dec, same key, cold cache:
  - o_Valid first rises 11 cycles after start with idx 10 = d014f9a8...0ca6.
  - Then idx 1 = a0fafe17...7605 and idx 0 = 2b7e1516...4f3c with o_Last=1.
- Repeat dec with same key (DEC_CACHE=1): o_Valid 1 cycle after start with idx 10 key. A different key instead re-enters EXPAND (11-cycle latency).
- Random i_Ready backpressure in both modes:
  - Outputs hold stable while stalled.
  - The accepted sequence is identical to the unstalled one, with no skipped or duplicated idx.
- i_Abort at EXPAND cycle 5, then dec start with same key: full 11-cycle latency, since the cache was not written. i_Start pulses mid-EMIT are ignored.
- Synchronous reset asserted mid-EMIT:
  - All outputs 0 at the next edge and cache invalid.
  - A subsequent enc start yields idx 0 one cycle later.
